// File: rtl/mem_write_checker_pkg.sv
// Shared types and helpers for the data-memory store checker.
package mem_check_pkg;

  // Checker state, with a fixed two-bit encoding so the value stays stable across tools
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  // Limits a requested table length to the number of physical entries
  function automatic int clamp_len(input int len, input int depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/mem_write_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Count up while enabled, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory store bus and checks stores, in order, against a
// programmable table of expected (address, data) pairs. It reports pass, fail
// or timeout, and captures the first offending store.
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 4,
  parameter int               CNT_W      = 16,
  parameter int               TIMEOUT    = 1000,
  parameter int               IGNORE_EN  = 1,
  parameter logic [WIDTH-1:0] IGNORE_ADR = WIDTH'(80)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]           cfg_adr,
  input  logic [WIDTH-1:0]           cfg_data,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [WIDTH-1:0]           fail_adr,
  output logic [WIDTH-1:0]           fail_data,
  output logic [CNT_W-1:0]           write_count,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH+1);
  // The timeout fires when the cycle counter sits at this value
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] data;
  } exp_entry_t;

  exp_entry_t       exp_table [DEPTH];
  exp_entry_t       cur_exp;
  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_next;
  logic             run;
  logic             start_ok;
  logic             store_match;
  logic             store_ignore;
  logic             store_bad;
  logic             final_match;
  logic             timeout_fire;
  logic             cnt_write_en;
  logic             cnt_cycle_en;

  // Classify the current store and pick the next state; start beats everything,
  // a final match beats a coincident timeout
  always_comb begin
    run          = (state == RUN);
    start_ok     = start && !run;
    len_next     = LEN_W'(clamp_len(int'(cfg_len), DEPTH));
    cur_exp      = exp_table[idx];
    store_match  = run && memwrite && (dataadr == cur_exp.adr) && (writedata == cur_exp.data);
    store_ignore = run && memwrite && !store_match && (IGNORE_EN != 0) && (dataadr == IGNORE_ADR);
    store_bad    = run && memwrite && !store_match && !store_ignore;
    final_match  = store_match && (LEN_W'(idx) == (len - LEN_W'(1)));
    timeout_fire = run && (TIMEOUT != 0) && (cycle_count == TIMEOUT_LAST) && !final_match && !store_bad;
    cnt_write_en = run && memwrite;
    // The cycle counter freezes on the timeout cycle so it reads TIMEOUT-1 afterwards
    cnt_cycle_en = run && !timeout_fire;

    next_state = state;
    if (start_ok) begin
      next_state = (len_next == '0) ? PASS : RUN;
    end else if (final_match) begin
      next_state = PASS;
    end else if (store_bad || timeout_fire) begin
      next_state = FAIL;
    end
  end

  // State register plus status outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == PASS) || (next_state == FAIL);
      pass  <= (next_state == PASS);
      fail  <= (next_state == FAIL);
      if (start_ok) begin
        timeout <= 1'b0;
      end else if (timeout_fire) begin
        timeout <= 1'b1;
      end
    end
  end

  // Table position, latched length, and capture of the first offending store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      len       <= '0;
      fail_idx  <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (start_ok) begin
      idx       <= '0;
      len       <= len_next;
      fail_idx  <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else begin
      if (store_match) begin
        idx <= idx + IDX_W'(1);
      end
      if (store_bad) begin
        fail_idx  <= idx;
        fail_adr  <= dataadr;
        fail_data <= writedata;
      end else if (timeout_fire) begin
        fail_idx <= idx;
      end
    end
  end

  // Expected-store table, writable only while the checker is not running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_table[i] <= '0;
      end
    end else if (cfg_we && !run && (int'(cfg_idx) < DEPTH)) begin
      exp_table[cfg_idx].adr  <= cfg_adr;
      exp_table[cfg_idx].data <= cfg_data;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_write_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (cnt_write_en),
    .q     (write_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (cnt_cycle_en),
    .q     (cycle_count)
  );

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker with a short timeout so the timeout paths are reachable.
module tb_mem_write_checker;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_adr;
  logic [31:0] cfg_data;
  logic [2:0]  cfg_len;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [1:0]  fail_idx;
  logic [31:0] fail_adr;
  logic [31:0] fail_data;
  logic [15:0] write_count;
  logic [15:0] cycle_count;

  int checks = 0;
  int passed = 0;

  mem_write_checker #(
    .WIDTH(32), .DEPTH(4), .CNT_W(16), .TIMEOUT(20), .IGNORE_EN(1), .IGNORE_ADR(32'd80)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .start(start), .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .fail_adr(fail_adr), .fail_data(fail_data),
    .write_count(write_count), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_adr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm(input logic [2:0] l);
    cfg_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0; cfg_len = '0; start = 1'b0;
    idle(2);
    checks++; if ({busy, done, pass, fail, timeout} !== 5'b0) $display("[TB] FAIL rst_flags: got %b want 00000", {busy, done, pass, fail, timeout}); else passed++;
    checks++; if (write_count !== 16'd0 || cycle_count !== 16'd0) $display("[TB] FAIL rst_counts: got %0d/%0d want 0/0", write_count, cycle_count); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ignore_then_pass();
    cfg_write(2'd0, 32'd84, 32'd7);
    arm(3'd1);
    store(32'd80, 32'd5);
    checks++; if (busy !== 1'b1 || pass !== 1'b0) $display("[TB] FAIL t1_ignore: got busy=%b pass=%b want 1/0", busy, pass); else passed++;
    store(32'd84, 32'd7);
    checks++; if (pass !== 1'b1 || done !== 1'b1) $display("[TB] FAIL t1_pass: got pass=%b done=%b want 1/1", pass, done); else passed++;
    checks++; if (write_count !== 16'd2) $display("[TB] FAIL t1_wcount: got %0d want 2", write_count); else passed++;
    checks++; if (fail !== 1'b0 || timeout !== 1'b0) $display("[TB] FAIL t1_nofail: got fail=%b to=%b want 0/0", fail, timeout); else passed++;
  endtask

  task automatic test_bad_address();
    arm(3'd1);
    store(32'd88, 32'd7);
    checks++; if (fail !== 1'b1 || pass !== 1'b0) $display("[TB] FAIL t2_fail: got fail=%b pass=%b want 1/0", fail, pass); else passed++;
    checks++; if (fail_idx !== 2'd0) $display("[TB] FAIL t2_idx: got %0d want 0", fail_idx); else passed++;
    checks++; if (fail_adr !== 32'd88 || fail_data !== 32'd7) $display("[TB] FAIL t2_capture: got %0d/%0d want 88/7", fail_adr, fail_data); else passed++;
  endtask

  task automatic test_order();
    cfg_write(2'd0, 32'd4, 32'd1);
    cfg_write(2'd1, 32'd8, 32'd2);
    cfg_write(2'd2, 32'd12, 32'd3);
    arm(3'd3);
    store(32'd8, 32'd2);
    checks++; if (fail !== 1'b1 || fail_idx !== 2'd0) $display("[TB] FAIL t3_order: got fail=%b idx=%0d want 1/0", fail, fail_idx); else passed++;
    arm(3'd3);
    checks++; if (busy !== 1'b1 || fail !== 1'b0 || fail_adr !== 32'd0) $display("[TB] FAIL t3_restart: got busy=%b fail=%b adr=%0d want 1/0/0", busy, fail, fail_adr); else passed++;
    store(32'd4, 32'd1);
    store(32'd9, 32'd2);
    checks++; if (fail !== 1'b1 || fail_idx !== 2'd1 || fail_adr !== 32'd9) $display("[TB] FAIL t3_idx1: got fail=%b idx=%0d adr=%0d want 1/1/9", fail, fail_idx, fail_adr); else passed++;
    arm(3'd3);
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    checks++; if (busy !== 1'b1 || pass !== 1'b0) $display("[TB] FAIL t3_mid: got busy=%b pass=%b want 1/0", busy, pass); else passed++;
    store(32'd12, 32'd3);
    checks++; if (pass !== 1'b1 || write_count !== 16'd3) $display("[TB] FAIL t3_pass: got pass=%b wc=%0d want 1/3", pass, write_count); else passed++;
  endtask

  task automatic test_timeout();
    arm(3'd1);
    store(32'd80, 32'd1);
    store(32'd80, 32'd2);
    store(32'd80, 32'd3);
    checks++; if (write_count !== 16'd3 || busy !== 1'b1) $display("[TB] FAIL t4_ignored: got wc=%0d busy=%b want 3/1", write_count, busy); else passed++;
    idle(16);
    checks++; if (busy !== 1'b1 || fail !== 1'b0 || cycle_count !== 16'd19) $display("[TB] FAIL t4_early: got busy=%b fail=%b cc=%0d want 1/0/19", busy, fail, cycle_count); else passed++;
    tick();
    checks++; if (fail !== 1'b1 || timeout !== 1'b1) $display("[TB] FAIL t4_to: got fail=%b to=%b want 1/1", fail, timeout); else passed++;
    checks++; if (cycle_count !== 16'd19 || fail_idx !== 2'd0) $display("[TB] FAIL t4_cc: got cc=%0d idx=%0d want 19/0", cycle_count, fail_idx); else passed++;
    checks++; if (fail_adr !== 32'd0 || fail_data !== 32'd0 || write_count !== 16'd3) $display("[TB] FAIL t4_capture: got %0d/%0d wc=%0d want 0/0/3", fail_adr, fail_data, write_count); else passed++;
  endtask

  task automatic test_async_reset();
    arm(3'd3);
    store(32'd4, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({busy, done, pass, fail, timeout} !== 5'b0) $display("[TB] FAIL t5_flags: got %b want 00000", {busy, done, pass, fail, timeout}); else passed++;
    checks++; if (write_count !== 16'd0 || cycle_count !== 16'd0) $display("[TB] FAIL t5_counts: got %0d/%0d want 0/0", write_count, cycle_count); else passed++;
    #2;
    reset = 1'b0;
    store(32'd4, 32'd1);
    checks++; if (write_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL t5_idle: got wc=%0d busy=%b done=%b want 0/0/0", write_count, busy, done); else passed++;
    arm(3'd0);
    checks++; if (pass !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL t5_len0: got pass=%b busy=%b want 1/0", pass, busy); else passed++;
    arm(3'd1);
    store(32'd0, 32'd0);
    checks++; if (pass !== 1'b1 || fail !== 1'b0) $display("[TB] FAIL t5_cleared: got pass=%b fail=%b want 1/0", pass, fail); else passed++;
  endtask

  task automatic test_pass_beats_timeout();
    cfg_write(2'd0, 32'd4, 32'd1);
    cfg_write(2'd1, 32'd8, 32'd2);
    cfg_write(2'd2, 32'd12, 32'd3);
    cfg_write(2'd3, 32'd16, 32'd4);
    arm(3'd3);
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    idle(17);
    checks++; if (cycle_count !== 16'd19 || busy !== 1'b1) $display("[TB] FAIL t6_cc: got cc=%0d busy=%b want 19/1", cycle_count, busy); else passed++;
    store(32'd12, 32'd3);
    checks++; if (pass !== 1'b1 || timeout !== 1'b0 || fail !== 1'b0) $display("[TB] FAIL t6_win: got pass=%b to=%b fail=%b want 1/0/0", pass, timeout, fail); else passed++;
  endtask

  task automatic test_back_to_back();
    arm(3'd3);
    checks++; if (busy !== 1'b1 || pass !== 1'b0 || write_count !== 16'd0 || cycle_count !== 16'd0) $display("[TB] FAIL t7_rearm: got busy=%b pass=%b wc=%0d cc=%0d want 1/0/0/0", busy, pass, write_count, cycle_count); else passed++;
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    store(32'd12, 32'd3);
    checks++; if (pass !== 1'b1) $display("[TB] FAIL t7_pass3: got %b want 1", pass); else passed++;
    arm(3'd7);
    cfg_write(2'd0, 32'd100, 32'd100);
    store(32'd4, 32'd1);
    checks++; if (busy !== 1'b1 || fail !== 1'b0) $display("[TB] FAIL t7_cfg_run: got busy=%b fail=%b want 1/0", busy, fail); else passed++;
    store(32'd8, 32'd2);
    store(32'd12, 32'd3);
    checks++; if (busy !== 1'b1 || pass !== 1'b0) $display("[TB] FAIL t7_clamp_mid: got busy=%b pass=%b want 1/0", busy, pass); else passed++;
    store(32'd16, 32'd4);
    checks++; if (pass !== 1'b1 || write_count !== 16'd4) $display("[TB] FAIL t7_clamp: got pass=%b wc=%0d want 1/4", pass, write_count); else passed++;
    store(32'd99, 32'd99);
    checks++; if (pass !== 1'b1 || write_count !== 16'd4) $display("[TB] FAIL t7_sticky: got pass=%b wc=%0d want 1/4", pass, write_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_ignore_then_pass();
    test_bad_address();
    test_order();
    test_timeout();
    test_async_reset();
    test_pass_beats_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable self-check monitor for the multicycle MIPS data-memory bus. It watches memwrite/dataadr/writedata and compares every store against a programmable table of expected (address, data) pairs, in order. It reports pass, fail or timeout, with write and cycle counts and capture of the first offending store. It sits beside top in simulation and FPGA bring-up, and replaces hard-coded end-of-program address/data checks.

Parameters:
WIDTH, 32, width of dataadr/writedata and of table entries
DEPTH, 4, number of expected-store table entries
CNT_W, 16, width of write and cycle counters
TIMEOUT, 1000, cycles in RUN before forced fail; 0 disables the timeout
IGNORE_EN, 1, enables the ignore address
IGNORE_ADR, 80, store address that is counted but not compared

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
memwrite  in  1  store strobe from core
dataadr  in  WIDTH  store address
writedata  in  WIDTH  store data
cfg_we  in  1  table write enable
cfg_idx  in  $clog2(DEPTH)  table entry index
cfg_adr  in  WIDTH  expected address
cfg_data  in  WIDTH  expected data
cfg_len  in  $clog2(DEPTH+1)  number of valid entries
start  in  1  arm checker (one-cycle pulse)
busy  out  1  state is RUN
done  out  1  state is PASS or FAIL
pass  out  1  all entries matched
fail  out  1  mismatch or timeout
timeout  out  1  fail caused by timeout
fail_idx  out  $clog2(DEPTH)  entry index expected at failure
fail_adr  out  WIDTH  offending store address
fail_data  out  WIDTH  offending store data
write_count  out  CNT_W  stores seen since start, saturating
cycle_count  out  CNT_W  cycles in RUN since start, saturating

Behaviour:
- States: IDLE, RUN, PASS, FAIL. All outputs are registered.
- Reset (async): state IDLE; every output 0; table entries, idx and len cleared to 0.
- Config:
  - cfg_we is accepted in IDLE, PASS and FAIL, and ignored in RUN.
  - cfg_idx >= DEPTH is ignored.
  - len is latched from cfg_len on start, clamped to DEPTH.
- start (any non-RUN state):
  - Clears counters, idx, pass, fail, timeout and the fail_* outputs.
  - If clamped len == 0, go to PASS next cycle; otherwise go to RUN.
  - start during RUN is ignored.
- RUN, each cycle:
  - cycle_count increments, saturating at all-ones.
  - If memwrite: write_count increments (saturating), then priority order applies:
    - (a) dataadr == table[idx].adr and writedata == table[idx].data: idx++. If idx == len-1, go to PASS.
    - (b) Else if IGNORE_EN and dataadr == IGNORE_ADR: no compare, stay in RUN.
    - (c) Else go to FAIL; capture fail_idx = idx, fail_adr = dataadr, fail_data = writedata.
  - Timeout: if TIMEOUT != 0 and cycle_count == TIMEOUT-1 with no transition this cycle, go to FAIL with timeout = 1 and fail_idx = idx; fail_adr and fail_data stay 0.
  - If a final match and the timeout occur in the same cycle, pass wins.
- Latency: pass or fail is visible on the rising edge after the deciding store is sampled; a bench checking on negedge sees it one cycle later.
- PASS and FAIL are sticky until start or reset. Stores in these states are not counted.
- memwrite in IDLE is ignored.
- Compares use ==, so an X on the bus yields X results; the bench treats X as fail.

Decomposition:
- Shared package mem_check_pkg:
  - state_t enum {IDLE, RUN, PASS, FAIL}
  - packed struct exp_entry_t {adr, data} parametrised by WIDTH through a typedef in the module
- One sub-module: sat_counter (width parameter; clr, en, q; saturating, async reset). Instantiated for write_count and cycle_count.

Test Plan:
1. Table {(84,7)}, len=1; start; stores (80,5) then (84,7) -> pass=1 one edge after the 2nd store, write_count=2, fail=0, timeout=0.
2. Same table; store (88,7) -> fail=1, fail_idx=0, fail_adr=88, fail_data=7, pass=0.
3. Table {(4,1),(8,2),(12,3)}, len=3; store (8,2) first -> fail, fail_idx=0. Restart with the correct order -> pass after the 3rd store, write_count=3.
4. TIMEOUT=20; start; no stores -> fail=1 and timeout=1 exactly 20 cycles after RUN entry, cycle_count=19, fail_idx=0. With IGNORE_EN, repeated (80,x) stores only increase write_count.
5. Reset pulsed mid-RUN after 1 of 3 matches, asynchronously between edges -> all outputs 0 immediately, state IDLE, table cleared. A later start with len=0 -> pass next cycle.
6. TIMEOUT=20, final matching store at cycle_count=19 -> pass=1, timeout=0. start in PASS -> busy=1, counters 0. start with cfg_len=7, DEPTH=4 -> len clamped to 4.
